// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Self-check block that watches the core's data-memory write bus and
//   compares each store against a programmable table of expected
//   (address, data) pairs. It ends in PASS, FAIL (mismatching store) or
//   TIMEOUT, and captures the offending store for diagnosis.
//
//   Optional build macro: MWCHK_UNORDERED_EN
//     undefined : entries must be matched strictly in table order
//     defined   : entries may match in any order (hit mask per entry)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   exp_we     in   table write strobe (ignored in RUN)
//   exp_idx    in   table entry index (>= NUM_EXP ignored)
//   exp_adr    in   expected address
//   exp_data   in   expected data
//   start      in   pulse: clear status and enter RUN (ignored in RUN)
//   mem_write  in   core MemWrite
//   data_adr   in   core DataAdr
//   write_data in   core WriteData
//   done       out  high in PASS, FAIL or TIMEOUT
//   pass       out  high in PASS
//   fail_code  out  0 none, 1 mismatch, 2 timeout
//   match_cnt  out  expected stores matched so far
//   cycle_cnt  out  RUN cycles elapsed, saturating
//   fail_adr   out  address of the offending store
//   fail_data  out  data of the offending store
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | checking stores, counting cycles
// S_PASS  | every expected store seen
// S_FAIL  | a store matched neither the table nor the ignore window
// S_TMO   | TIMEOUT RUN cycles elapsed without a decision

module mem_write_checker #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int NUM_EXP  = 4,
  parameter int IGN_BASE = 96,
  parameter int IGN_SIZE = 4,
  parameter int TIMEOUT  = 100000,
  localparam int IW      = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int CW      = $clog2(NUM_EXP + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_adr,
  input  logic [DW-1:0] exp_data,
  input  logic          start,
  input  logic          mem_write,
  input  logic [AW-1:0] data_adr,
  input  logic [DW-1:0] write_data,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [CW-1:0] match_cnt,
  output logic [31:0]   cycle_cnt,
  output logic [AW-1:0] fail_adr,
  output logic [DW-1:0] fail_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  // Window bounds carry one extra bit so IGN_BASE+IGN_SIZE never wraps.
  localparam logic [AW:0] IGN_LO = (AW+1)'(IGN_BASE);
  localparam logic [AW:0] IGN_HI = (AW+1)'(IGN_BASE) + (AW+1)'(IGN_SIZE);

  // Timeout down-counter reload: terminal count (zero) lands on the edge
  // where cycle_cnt+1 reaches TIMEOUT.
  localparam logic [31:0] TMO_LOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t state, state_nxt;

  logic [AW-1:0] tbl_adr  [NUM_EXP];
  logic [DW-1:0] tbl_data [NUM_EXP];

  logic [NUM_EXP-1:0] eq;
  logic               hit;
  logic               all_hit;
  logic [CW-1:0]      cnt_nxt;
  logic               in_ign;
  logic               store_hit;
  logic               store_bad;
  logic               tmo_fire;
  logic [31:0]        tmo_cnt;

  // Table storage is deliberately not reset so it survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (exp_we && (state != S_RUN) && (32'(exp_idx) < NUM_EXP)) begin
      tbl_adr[exp_idx]  <= exp_adr;
      tbl_data[exp_idx] <= exp_data;
    end
  end

  always_comb begin
    eq = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      eq[i] = (tbl_adr[i] == data_adr) && (tbl_data[i] == write_data);
    end
  end

`ifdef MWCHK_UNORDERED_EN
  logic [NUM_EXP-1:0] hit_mask;
  logic [NUM_EXP-1:0] avail;
  logic [NUM_EXP-1:0] pick;
  logic [NUM_EXP-1:0] mask_nxt;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_EXP-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_EXP; i++) begin
      c = c + CW'(m[i]);
    end
    return c;
  endfunction

  // Only un-hit entries can match; take the lowest such index.
  always_comb begin
    avail    = eq & ~hit_mask;
    pick     = avail & (~avail + NUM_EXP'(1));
    hit      = |avail;
    mask_nxt = hit_mask | pick;
    all_hit  = &mask_nxt;
    cnt_nxt  = popcnt(mask_nxt);
  end
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if ((match_cnt == CW'(i)) && eq[i]) hit = 1'b1;
    end
    cnt_nxt = match_cnt + CW'(1);
    all_hit = (cnt_nxt == CW'(NUM_EXP));
  end
`endif

  assign in_ign    = ({1'b0, data_adr} >= IGN_LO) && ({1'b0, data_adr} < IGN_HI);
  assign store_hit = mem_write && hit;
  assign store_bad = mem_write && !hit && !in_ign;
  assign tmo_fire  = (TIMEOUT > 0) && (tmo_cnt == 32'd0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a deciding store outranks the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (store_hit && all_hit) state_nxt = S_PASS;
        else if (store_bad)       state_nxt = S_FAIL;
        else if (tmo_fire)        state_nxt = S_TMO;
      end
      default: begin
        if (start) state_nxt = S_RUN;
      end
    endcase
  end

  // Output decode
  always_comb begin
    done      = 1'b0;
    pass      = 1'b0;
    fail_code = 2'd0;
    case (state)
      S_PASS: begin done = 1'b1; pass = 1'b1; end
      S_FAIL: begin done = 1'b1; fail_code = 2'd1; end
      S_TMO:  begin done = 1'b1; fail_code = 2'd2; end
      default: ;
    endcase
  end

  // Run counters and failure capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
      tmo_cnt   <= '0;
`ifdef MWCHK_UNORDERED_EN
      hit_mask  <= '0;
`endif
    end else if (state != S_RUN) begin
      if (start) begin
        match_cnt <= '0;
        cycle_cnt <= '0;
        fail_adr  <= '0;
        fail_data <= '0;
        tmo_cnt   <= TMO_LOAD;
`ifdef MWCHK_UNORDERED_EN
        hit_mask  <= '0;
`endif
      end
    end else begin
      if (cycle_cnt != '1)    cycle_cnt <= cycle_cnt + 32'd1;
      if (tmo_cnt != 32'd0)   tmo_cnt   <= tmo_cnt - 32'd1;
      if (store_hit) begin
        match_cnt <= cnt_nxt;
`ifdef MWCHK_UNORDERED_EN
        hit_mask  <= mask_nxt;
`endif
      end else if (store_bad) begin
        fail_adr  <= data_adr;
        fail_data <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  localparam int NE = 3;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exp_we = 1'b0;
  logic [1:0]  exp_idx = '0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        start = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] write_data = '0;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [1:0]  match_cnt;
  logic [31:0] cycle_cnt;
  logic [31:0] fail_adr;
  logic [31:0] fail_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] t_adr  [NE];
  logic [31:0] t_data [NE];
  bit          s_we   [TO];
  logic [31:0] s_adr  [TO];
  logic [31:0] s_data [TO];

  mem_write_checker #(
    .AW(32), .DW(32), .NUM_EXP(NE), .IGN_BASE(96), .IGN_SIZE(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
    .start(start), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done), .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt),
    .cycle_cnt(cycle_cnt), .fail_adr(fail_adr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk the store schedule cycle by cycle applying the rules
  // directly; returns the deciding RUN edge and the final status.
  task automatic model(output int d, output int code, output int mc,
                       output logic [31:0] fa, output logic [31:0] fd);
    bit [NE-1:0] used;
    bit hit;
    d = TO - 1; code = 2; mc = 0; fa = 0; fd = 0; used = '0;
    for (int j = 0; j < TO; j++) begin
      if (s_we[j]) begin
        hit = 0;
`ifdef MWCHK_UNORDERED_EN
        for (int i = 0; i < NE; i++)
          if (!hit && !used[i] && t_adr[i] == s_adr[j] && t_data[i] == s_data[j]) begin
            used[i] = 1; hit = 1;
          end
`else
        hit = (t_adr[mc] == s_adr[j]) && (t_data[mc] == s_data[j]);
`endif
        if (hit) begin
          mc++;
          if (mc == NE) begin d = j; code = 0; return; end
        end else if (!(s_adr[j] >= 96 && s_adr[j] < 100)) begin
          d = j; code = 1; fa = s_adr[j]; fd = s_data[j]; return;
        end
      end
      if (j + 1 == TO) begin d = j; code = 2; return; end
    end
  endtask

  task automatic load_table(input logic [31:0] a0, d0, a1, d1, a2, d2);
    t_adr[0] = a0; t_data[0] = d0;
    t_adr[1] = a1; t_data[1] = d1;
    t_adr[2] = a2; t_data[2] = d2;
    for (int i = 0; i < NE; i++) begin
      @(negedge clk);
      exp_we = 1; exp_idx = 2'(i); exp_adr = t_adr[i]; exp_data = t_data[i];
    end
    @(negedge clk);
    exp_idx = 2'd3; exp_adr = 0; exp_data = 0;   // out-of-range index, must not land
    @(negedge clk);
    exp_we = 0;
  endtask

  task automatic clear_sched();
    for (int j = 0; j < TO; j++) begin s_we[j] = 0; s_adr[j] = 0; s_data[j] = 0; end
  endtask

  task automatic put(input int j, input logic [31:0] a, input logic [31:0] d);
    s_we[j] = 1; s_adr[j] = a; s_data[j] = d;
  endtask

  task automatic run_sched(input string tag, input bit we_in_run);
    int d, code, mc;
    logic [31:0] fa, fd;
    bit early;
    model(d, code, mc, fa, fd);
    @(negedge clk);
    start = 1; mem_write = 1; data_adr = 32'h10; write_data = '1;  // outside RUN: no effect
    @(negedge clk);
    start = 0; early = 0;
    for (int j = 0; j <= d; j++) begin
      mem_write = s_we[j]; data_adr = s_adr[j]; write_data = s_data[j];
      if (we_in_run && j == 0) begin
        exp_we = 1; exp_idx = 0; exp_adr = 0; exp_data = 0;
      end
      @(negedge clk);
      exp_we = 0;
      if (j < d && done) early = 1;
    end
    mem_write = 0;
    chk({tag, ":no_early_done"}, early, 0);
    chk({tag, ":done"}, done, 1);
    chk({tag, ":pass"}, pass, code == 0);
    chk({tag, ":fail_code"}, fail_code, code);
    chk({tag, ":match_cnt"}, match_cnt, mc);
    chk({tag, ":cycle_cnt"}, cycle_cnt, d + 1);
    chk({tag, ":fail_adr"}, fail_adr, fa);
    chk({tag, ":fail_data"}, fail_data, fd);
    repeat (3) begin
      mem_write = 1; data_adr = 32'($urandom_range(90, 110)); write_data = 32'($urandom_range(0, 3));
      @(negedge clk);
    end
    mem_write = 0;
    chk({tag, ":hold_done"}, done, 1);
    chk({tag, ":hold_code"}, fail_code, code);
    chk({tag, ":hold_cycles"}, cycle_cnt, d + 1);
  endtask

  task automatic gen_random();
    int k, r, e;
    k = 0;
    clear_sched();
    for (int j = 0; j < TO; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 45) begin put(j, t_adr[k % NE], t_data[k % NE]); k++; end
        else if (r < 60) begin e = $urandom_range(0, NE - 1); put(j, t_adr[e], t_data[e]); end
        else if (r < 80) put(j, 32'(96 + $urandom_range(0, 3)), $urandom);
        else if (r < 90) put(j, ($urandom_range(0, 1) == 0) ? 32'd95 : 32'd100, 32'($urandom_range(0, 3)));
        else put(j, 32'($urandom_range(0, 300)), 32'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst:done", done, 0);
    chk("rst:pass", pass, 0);
    chk("rst:fail_code", fail_code, 0);
    chk("rst:match_cnt", match_cnt, 0);
    chk("rst:cycle_cnt", cycle_cnt, 0);
    chk("rst:fail_adr", fail_adr, 0);
    chk("rst:fail_data", fail_data, 0);
    reset = 1;

    load_table(100, 25, 104, 9, 108, 3);

    clear_sched(); put(2, 96, 7); put(5, 100, 25); put(6, 104, 9); put(9, 108, 3);
    run_sched("ordered_pass", 0);

    clear_sched(); put(0, 104, 9); put(2, 100, 25); put(3, 108, 3);
    run_sched("out_of_order", 0);

    clear_sched(); put(1, 100, 26);
    run_sched("bad_data", 0);

    clear_sched();
    run_sched("timeout", 0);

    clear_sched(); put(3, 100, 25); put(10, 104, 9); put(49, 108, 3);
    run_sched("pass_on_tmo_edge", 0);

    clear_sched(); put(0, 100, 25); put(49, 104, 9);
    run_sched("match_on_tmo_edge", 0);

    clear_sched(); put(0, 99, 5); put(1, 100, 25); put(4, 95, 1);
    run_sched("window_edges", 0);

    clear_sched(); put(0, 0, 0);
    run_sched("we_in_run", 1);
    clear_sched(); put(0, 100, 25); put(1, 104, 9); put(2, 108, 3);
    run_sched("after_we_in_run", 0);

    // Reset mid-run, then replay without reloading the table.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; mem_write = 1; data_adr = 100; write_data = 25;
    @(negedge clk); mem_write = 0;
    chk("mid_rst:match_before", match_cnt, 1);
    #2 reset = 0;
    #1;
    chk("mid_rst:done", done, 0);
    chk("mid_rst:match_cnt", match_cnt, 0);
    chk("mid_rst:cycle_cnt", cycle_cnt, 0);
    @(negedge clk); reset = 1;
    run_sched("after_mid_rst", 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        load_table(32'(100 + 4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                   32'(100 + 4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                   32'(100 + 4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      gen_random();
      run_sched($sformatf("rand%0d", n), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
